// File: rtl/charrom_ctrl_pkg.sv
// charrom_ctrl_pkg -- shared definitions for the character-ROM line fetcher.
//   state_t      : controller state encoding (IDLE/FETCH/DRAIN)
//   PIPE_LAT     : issue-to-FIFO-write latency in cycles
//   BLINK_PERIOD : line-0 linestarts per cursor blink toggle
package charrom_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PIPE_LAT     = 3;
  localparam int BLINK_PERIOD = 32;

endpackage

// File: rtl/charrom_ctrl_row.sv
// row_fifo -- small synchronous FIFO holding glyph rows for the pixel serializer.
// Ports:
//   clk, rst       clock, async active-high reset
//   push, wdata    write strobe / row data (caller guarantees not full)
//   pop            read strobe (ignored when empty)
//   rdata          head row, 0 when empty
//   valid          FIFO non-empty
//   count          number of rows held
module row_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign rdata  = valid ? mem[rptr] : '0;

  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end

endmodule

// File: rtl/charrom_ctrl.sv
// charrom_ctrl -- fetches one pixel line of glyph rows: reads the text buffer
// column by column, looks each glyph up in the charrom and queues the rows for
// the pixel serializer.
// Optional feature: define CHARROM_CTRL_CURSOR_EN to invert the row at the
// cursor cell (curaddr) while the blink bit is set.
// Ports:
//   clk, rst             clock, async active-high reset
//   linestart, line      fetch request pulse and pixel-line number
//   taddr, tren, tdata   text-buffer read port (1-cycle read latency)
//   readen, csel, y      charrom read port, rowout returns 2 cycles later
//   rowout               charrom row data
//   rowdata, rowvalid,   row stream to the serializer (valid/ready)
//   rowready
//   busy                 line fetch in progress
//   lineend              pulse when the line's last row enters the FIFO
//   overrun              pulse on an in-range linestart while busy
//   curaddr              cursor cell address (cursor build only)
module charrom_ctrl
  import charrom_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BITS  = 4,
  parameter int COLS  = 80,
  parameter int ROWS  = 30,
  parameter int ABITS = 12,
  parameter int LBITS = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             linestart,
  input  logic [LBITS-1:0] line,
  output logic [ABITS-1:0] taddr,
  output logic             tren,
  input  logic [BITS-1:0]  tdata,
  output logic             readen,
  output logic [BITS-1:0]  csel,
  output logic [2:0]       y,
  input  logic [WIDTH-1:0] rowout,
  output logic [WIDTH-1:0] rowdata,
  output logic             rowvalid,
  input  logic             rowready,
  output logic             busy,
  output logic             lineend,
  output logic             overrun,
  input  logic [ABITS-1:0] curaddr
);

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int STAGES = PIPE_LAT - 1;

  state_t           state;
  logic [ABITS-1:0] base, col;
  logic [STAGES:0]  vld_pipe;   // [0]=charrom read, [STAGES]=FIFO write
  logic [CW-1:0]    fcount;
  logic             in_range, start_ok, credit, issue, push, pop, last_wr;
  logic [WIDTH-1:0] wdata;

  assign in_range = int'(line) < ROWS * 8;
  assign start_ok = linestart && in_range;
  assign pop      = rowvalid && rowready;

  // Rows already committed (in flight or buffered) must fit in the FIFO.
  // A pop this cycle frees its slot immediately, which keeps issue at one
  // column per cycle when the consumer is streaming.
  assign credit = (int'(fcount) - int'(pop) + $countones(vld_pipe)) < DEPTH;
  assign issue  = (state == FETCH) && credit;

  assign tren    = issue;
  assign taddr   = issue ? base + col : '0;
  assign readen  = vld_pipe[0];
  assign csel    = vld_pipe[0] ? tdata : '0;
  assign push    = vld_pipe[STAGES];

  // No issues happen in DRAIN, so the write with an empty pipe behind it is the last one.
  assign last_wr = (state == DRAIN) && push && !(|vld_pipe[STAGES-1:0]);
  assign lineend = last_wr;
  assign busy    = (state != IDLE);
  assign overrun = start_ok && busy;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      base     <= '0;
      y        <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      unique case (state)
        IDLE:
          if (start_ok) begin
            state <= FETCH;
            y     <= line[2:0];
            base  <= ABITS'(int'(line[LBITS-1:3]) * COLS);
            col   <= '0;
          end
        FETCH:
          if (issue) begin
            col <= col + ABITS'(1);
            if (col == ABITS'(COLS - 1)) state <= DRAIN;
          end
        DRAIN:
          if (last_wr) state <= IDLE;
        default: state <= IDLE;
      endcase
    end

`ifdef CHARROM_CTRL_CURSOR_EN
  localparam int BW = $clog2(BLINK_PERIOD);

  logic [STAGES:0] hit_pipe;    // cursor match, aligned with vld_pipe
  logic [BW-1:0]   blink_cnt;
  logic            blink;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hit_pipe  <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      hit_pipe <= {hit_pipe[STAGES-1:0], issue && (base + col == curaddr)};
      // Only linestarts that actually begin a frame's first line count.
      if (state == IDLE && start_ok && line == '0) begin
        blink_cnt <= blink_cnt + BW'(1);
        if (blink_cnt == BW'(BLINK_PERIOD - 1)) blink <= ~blink;
      end
    end

  assign wdata = (hit_pipe[STAGES] && blink) ? ~rowout : rowout;
`else
  logic unused_curaddr;
  assign unused_curaddr = ^curaddr;
  assign wdata          = rowout;
`endif

  row_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rowdata),
    .valid (rowvalid),
    .count (fcount)
  );

endmodule

// File: tb/tb_charrom_ctrl.sv
// Self-checking bench for charrom_ctrl (default parameters). A row-level model
// tracks outstanding rows, expected addresses and row arrival cycles; one
// negedge process compares every output each cycle.
module tb_charrom_ctrl;

  localparam int COLS   = 80;
  localparam int DEPTH  = 4;
  localparam int NLINES = 30 * 8;

  logic        clk = 1'b0;
  logic        rst, linestart, tren, readen, rowvalid, rowready, busy, lineend, overrun;
  logic [7:0]  line;
  logic [11:0] taddr, curaddr;
  logic [3:0]  tdata, csel, rowout, rowdata, rp1;
  logic [2:0]  y;

  always #5 clk = ~clk;

  charrom_ctrl dut (
    .clk(clk), .rst(rst), .linestart(linestart), .line(line),
    .taddr(taddr), .tren(tren), .tdata(tdata),
    .readen(readen), .csel(csel), .y(y), .rowout(rowout),
    .rowdata(rowdata), .rowvalid(rowvalid), .rowready(rowready),
    .busy(busy), .lineend(lineend), .overrun(overrun), .curaddr(curaddr)
  );

  function automatic logic [3:0] glyph(input logic [11:0] a);
    int v;
    v = int'(a) * 7 + 3;
    return v[3:0];
  endfunction

  function automatic logic [3:0] rom(input logic [3:0] c, input logic [2:0] yy);
    int v;
    v = int'(c) * 5 + int'(yy) * 3 + 1;
    return v[3:0];
  endfunction

  // Text buffer (1-cycle) and charrom (2-cycle) models; random data when idle.
  always @(posedge clk) begin
    tdata  <= tren ? glyph(taddr) : 4'($urandom);
    rp1    <= readen ? rom(csel, y) : 4'($urandom);
    rowout <= rp1;
  end

  typedef struct { int ready; logic [3:0] data; int col; } row_t;
  row_t        q[$];
  row_t        r;
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  bit          mact = 0, ptren = 0, mblink = 0, exp_rv, exp_tren, exp_ovr, acc;
  int          m_issued = 0, m_base = 0, iss_tot = 0, pop_tot = 0, due = -1, n0 = 0;
  int          ls_cyc = 0, le_cyc = 0, tren_cnt = 0, ovr_cnt = 0, le_cnt = 0, ea;
  logic [2:0]  m_y = '0;
  logic [11:0] ptaddr = '0;
  logic [3:0]  d;
  logic [3:0]  got [COLS];
  int          rr_mode = 1;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("reset_outputs",
          int'({tren, readen, busy, lineend, overrun, rowvalid, taddr, csel, rowdata, y}), 0);
      q.delete();
      mact = 0; m_issued = 0; iss_tot = 0; pop_tot = 0; due = -1;
      ptren = 0; n0 = 0; mblink = 0;
    end else begin
      exp_rv = (q.size() != 0) ? (q[0].ready <= cyc) : 1'b0;
      chk("rowvalid", int'(rowvalid), int'(exp_rv));
      if (rowvalid && rowready && q.size() != 0) begin
        r = q.pop_front();
        chk("rowdata", int'(rowdata), int'(r.data));
        got[r.col] = rowdata;
        pop_tot++;
      end
      exp_tren = mact && (m_issued < COLS) && (iss_tot - pop_tot < DEPTH);
      chk("tren", int'(tren), int'(exp_tren));
      if (tren && exp_tren) begin
        ea = m_base + m_issued;
        chk("taddr", int'(taddr), ea);
        chk("y", int'(y), int'(m_y));
        d = rom(glyph(12'(ea)), m_y);
`ifdef CHARROM_CTRL_CURSOR_EN
        if (ea == int'(curaddr) && mblink) d = ~d;
`endif
        q.push_back('{cyc + 4, d, m_issued});
        m_issued++; iss_tot++; tren_cnt++;
        if (m_issued == COLS) due = cyc + 3;
      end
      chk("readen", int'(readen), int'(ptren));
      if (ptren && readen) chk("csel", int'(csel), int'(glyph(ptaddr)));
      ptren  = tren;
      ptaddr = taddr;
      chk("lineend", int'(lineend), int'(cyc == due));
      acc     = linestart && !mact && (int'(line) < NLINES);
      exp_ovr = linestart && mact && (int'(line) < NLINES);
      chk("overrun", int'(overrun), int'(exp_ovr));
      chk("busy", int'(busy), int'(mact));
      if (lineend) le_cnt++;
      if (overrun) ovr_cnt++;
      if (cyc == due) begin mact = 0; le_cyc = cyc; end
      if (acc) begin
        mact = 1; m_issued = 0; due = -1; ls_cyc = cyc;
        m_base = (int'(line) / 8) * COLS;
        m_y    = line[2:0];
        if (line == 8'd0) begin n0++; mblink = ((n0 / 32) % 2) == 1; end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (rr_mode)
      0:       rowready = 1'b0;
      1:       rowready = 1'b1;
      default: rowready = ($urandom_range(0, 2) != 0);
    endcase
  end

  task automatic start(input int l);
    @(posedge clk); #1;
    line = 8'(l); linestart = 1'b1;
    @(posedge clk); #1;
    linestart = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((mact || q.size() != 0) && n < budget) begin @(posedge clk); n++; end
    #1;
    chk("drain_timeout", int'(mact || q.size() != 0), 0);
  endtask

  int t0, p0, o0, e0, n;

  initial begin
    rst = 1'b1; linestart = 1'b0; line = '0; curaddr = 12'd85;
    repeat (3) @(posedge clk); #1 rst = 1'b0;

    // Unthrottled line 10: base 80, y 2.
    t0 = tren_cnt; start(10); wait_idle(400);
    chk("l10_issues", tren_cnt - t0, 80);
    chk("l10_latency", le_cyc - ls_cyc, 83);
    chk("l10_row0", int'(got[0]), 6);
    chk("l10_row5", int'(got[5]), 5);
    chk("l10_row79", int'(got[79]), 3);

    // Consumer stalled: only DEPTH columns may be issued.
    rr_mode = 0; t0 = tren_cnt; p0 = pop_tot;
    start($urandom_range(0, NLINES - 1));
    repeat (30) @(posedge clk); #1;
    chk("bp_stall_issues", tren_cnt - t0, 4);
    rr_mode = 2; wait_idle(2000); rr_mode = 1;
    chk("bp_issues", tren_cnt - t0, 80);
    chk("bp_rows", pop_tot - p0, 80);

    // Second linestart five cycles into a line.
    t0 = tren_cnt; o0 = ovr_cnt; e0 = le_cnt;
    start(33);
    repeat (3) @(posedge clk);
    start(70);
    wait_idle(400);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    chk("ovr_lineends", le_cnt - e0, 1);
    chk("ovr_issues", tren_cnt - t0, 80);

    // Out-of-range lines are ignored.
    t0 = tren_cnt; e0 = le_cnt;
    start(NLINES); start(255);
    repeat (10) @(posedge clk); #1;
    chk("oor_issues", tren_cnt - t0, 0);
    chk("oor_lineends", le_cnt - e0, 0);

    // Reset once column 40 has been issued, then a clean line.
    start(100);
    n = 0;
    while (m_issued < 40 && n < 300) begin @(posedge clk); n++; end
    #1 chk("rst_col40_reached", int'(m_issued >= 40), 1);
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    t0 = tren_cnt; start(57); wait_idle(400);
    chk("post_rst_issues", tren_cnt - t0, 80);
    chk("post_rst_row0", int'(got[0]), 3);

    // Cursor cell 85 on line 8 (col 5): blink off, then after 32 frame starts.
    start(8); wait_idle(400);
    chk("cur_off_row5", int'(got[5]), 15);
    for (int i = 0; i < 32; i++) begin start(0); wait_idle(400); end
    start(8); wait_idle(400);
    chk("cur_row4", int'(got[4]), 12);
`ifdef CHARROM_CTRL_CURSOR_EN
    chk("cur_on_row5", int'(got[5]), 0);
`else
    chk("cur_on_row5", int'(got[5]), 15);
`endif

    // Random lines, random consumer, occasional mid-line linestart.
    rr_mode = 2;
    for (int i = 0; i < 12; i++) begin
      start($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        start($urandom_range(0, 255));
      end
      wait_idle(1500);
    end
    chk("final_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
